// File: rtl/parity_generator_pkg.sv
// Shared parity helpers and encodings used by the parity generator and checker.
// Functions work on a MAX_W-bit zero-extended payload so one body serves every width.
package parity_pkg;

   localparam int MAX_W = 64;

   typedef enum logic {EVEN = 1'b0, ODD = 1'b1} parity_sense_e;
   typedef enum logic {LSB = 1'b0, MSB = 1'b1} parity_pos_e;
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} skid_state_e;

   // Zero padding does not change the XOR reduction, so callers may zero-extend freely.
   function automatic logic calc_parity(input logic [MAX_W-1:0] data,
                                        input parity_sense_e    even_odd);
      return (^data) ^ even_odd;
   endfunction

   function automatic logic [MAX_W:0] insert_parity(input logic [MAX_W-1:0] data,
                                                    input logic             p,
                                                    input parity_pos_e      select,
                                                    input int               width);
      logic [MAX_W:0] r;
      if (select == MSB) begin
         r = {1'b0, data} | ((MAX_W+1)'(p) << width);
      end else begin
         r = {data, p};
      end
      return r;
   endfunction

endpackage

// File: rtl/parity_generator_if.sv
// Producer-side and FIFO-side valid/grant handshakes of the parity generator.
// master is the generator's view; slave is the surrounding producer/FIFO view.
interface parity_generator_if #(
   parameter int DATA_WIDTH = 8
) ();

   logic                  push_valid_sender;
   logic [DATA_WIDTH-1:0] push_data_sender;
   logic                  push_grant_sender;
   logic                  push_valid_fifo;
   logic [DATA_WIDTH:0]   push_data_fifo;
   logic                  push_grant_fifo;

   modport master (
      input  push_valid_sender,
      input  push_data_sender,
      output push_grant_sender,
      output push_valid_fifo,
      output push_data_fifo,
      input  push_grant_fifo
   );

   modport slave (
      output push_valid_sender,
      output push_data_sender,
      input  push_grant_sender,
      input  push_valid_fifo,
      input  push_data_fifo,
      output push_grant_fifo
   );

endinterface

// File: rtl/parity_generator_skid_buffer.sv
// Generic 2-entry valid/grant register slice: every output is a flop, full throughput.
// OUT drives the consumer; SKID catches the word accepted while OUT is stalled.
module skid_buffer
   import parity_pkg::*;
#(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_grant,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   input  logic             i_grant
);

   skid_state_e      r_state;
   skid_state_e      w_state_nxt;
   logic             r_valid;
   logic             r_grant;
   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_skid;
   logic             w_in_xfer;
   logic             w_out_xfer;
   logic             w_load_out;
   logic             w_load_skid;
   logic             w_out_from_skid;

   assign w_in_xfer  = i_valid & r_grant;
   assign w_out_xfer = r_valid & i_grant;

   always_comb begin
      w_state_nxt     = r_state;
      w_load_out      = 1'b0;
      w_load_skid     = 1'b0;
      w_out_from_skid = 1'b0;
      case (r_state)
         EMPTY: begin
            if (w_in_xfer) begin
               w_load_out  = 1'b1;
               w_state_nxt = ONE;
            end
         end
         ONE: begin
            if (w_in_xfer && w_out_xfer) begin
               w_load_out = 1'b1;
            end else if (w_in_xfer) begin
               w_load_skid = 1'b1;
               w_state_nxt = FULL;
            end else if (w_out_xfer) begin
               w_state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (w_out_xfer) begin
               w_out_from_skid = 1'b1;
               w_state_nxt     = ONE;
            end
         end
         default: w_state_nxt = EMPTY;
      endcase
   end

   // Valid and grant are kept as their own flops so neither output is a state decode.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= EMPTY;
         r_valid <= 1'b0;
         r_grant <= 1'b1;
         r_out   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_valid <= (w_state_nxt != EMPTY);
         r_grant <= (w_state_nxt != FULL);
         if (w_load_out) begin
            r_out <= i_data;
         end else if (w_out_from_skid) begin
            r_out <= r_skid;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_load_skid) begin
         r_skid <= i_data;
      end
   end

   assign o_grant = r_grant;
   assign o_valid = r_valid;
   assign o_data  = r_out;

endmodule

// File: rtl/parity_generator.sv
// Encodes producer words with a parity bit and pushes them to a FIFO through a skid buffer,
// with a one-shot parity corruption hook and a wrapping count of delivered words.
module parity_generator
   import parity_pkg::*;
#(
   parameter int EVEN_ODD          = 0,
   parameter int SELECT_PARITY_BIT = 0,
   parameter int DATA_WIDTH        = 8,
   parameter int COUNT_WIDTH       = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   parity_generator_if.master     bus,
   input  logic                   inject_error,
   output logic                   inject_pending,
   output logic [COUNT_WIDTH-1:0] tx_count
);

   localparam parity_sense_e LP_SENSE = (EVEN_ODD != 0) ? ODD : EVEN;
   localparam parity_pos_e   LP_POS   = (SELECT_PARITY_BIT != 0) ? MSB : LSB;

   logic                   r_inject_pending;
   logic [COUNT_WIDTH-1:0] r_tx_count;
   logic                   w_sender_xfer;
   logic                   w_fifo_xfer;
   logic                   w_corrupt;
   logic                   w_parity;
   logic [DATA_WIDTH:0]    w_enc;

   assign w_sender_xfer = bus.push_valid_sender & bus.push_grant_sender;
   assign w_fifo_xfer   = bus.push_valid_fifo & bus.push_grant_fifo;

   // A pulse coinciding with the transfer corrupts that same word.
   assign w_corrupt = r_inject_pending | inject_error;
   assign w_parity  = calc_parity(MAX_W'(bus.push_data_sender), LP_SENSE) ^ w_corrupt;
   assign w_enc     = (DATA_WIDTH+1)'(insert_parity(MAX_W'(bus.push_data_sender), w_parity,
                                                    LP_POS, DATA_WIDTH));

   skid_buffer #(
      .WIDTH (DATA_WIDTH + 1)
   ) u_skid (
      .clk     (clk),
      .reset   (reset),
      .i_valid (bus.push_valid_sender),
      .i_data  (w_enc),
      .o_grant (bus.push_grant_sender),
      .o_valid (bus.push_valid_fifo),
      .o_data  (bus.push_data_fifo),
      .i_grant (bus.push_grant_fifo)
   );

   // The consuming transfer wins over a simultaneous pulse, so pulses never stack.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_inject_pending <= 1'b0;
         r_tx_count       <= '0;
      end else begin
         if (w_sender_xfer) begin
            r_inject_pending <= 1'b0;
         end else if (inject_error) begin
            r_inject_pending <= 1'b1;
         end
         if (w_fifo_xfer) begin
            r_tx_count <= r_tx_count + 1'b1;
         end
      end
   end

   assign inject_pending = r_inject_pending;
   assign tx_count       = r_tx_count;

endmodule
